// File: rtl/trv_host_driver.sv
// Host-side master for the Trivium core strobe interface: serial key load, warm-up wait,
// byte-at-a-time encrypt with READ/STB_READ handshake and a bounded wait for the result.
module trv_host_driver #(
    parameter int unsigned KeyBits = 80,
    parameter int unsigned Warmup  = 1152,
    parameter int unsigned Timeout = 1023
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [KeyBits-1:0] key_in_i,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_last_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [7:0]         rx_data_o,
    output logic [7:0]         rx_sign_o,
    output logic               rx_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               key_o,
    output logic               stb_key_o,
    output logic [7:0]         data_o,
    output logic               stb_data_o,
    output logic               read_o,
    input  logic [7:0]         data_out_i,
    input  logic [7:0]         sign_reg_i,
    input  logic               stb_read_i
);

    localparam int unsigned BitW  = $clog2(KeyBits + 1);
    localparam int unsigned WarmW = (Warmup > 0) ? $clog2(Warmup + 1) : 1;
    localparam int unsigned WaitW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StKeyLoad,
        StWarmup,
        StWaitTx,
        StSend,
        StReq,
        StWaitRd
    } state_e;

    state_e             state_q;
    logic [KeyBits-1:0] key_sr_q;
    logic [BitW-1:0]    bit_cnt_q;
    logic [WarmW-1:0]   warm_cnt_q;
    logic [WaitW-1:0]   wait_cnt_q;
    logic               last_q;

    logic               tx_ready_q;
    logic [7:0]         rx_data_q;
    logic [7:0]         rx_sign_q;
    logic               rx_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               key_q;
    logic               stb_key_q;
    logic [7:0]         data_q;
    logic               stb_data_q;
    logic               read_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            key_sr_q   <= '0;
            bit_cnt_q  <= '0;
            warm_cnt_q <= '0;
            wait_cnt_q <= '0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_sign_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            key_q      <= 1'b0;
            stb_key_q  <= 1'b0;
            data_q     <= 8'h00;
            stb_data_q <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            // Pulses and bus drives fall back to idle values unless a state re-asserts them.
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            key_q      <= 1'b0;
            stb_key_q  <= 1'b0;
            data_q     <= 8'h00;
            stb_data_q <= 1'b0;
            read_q     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        key_q     <= key_in_i[0];
                        key_sr_q  <= key_in_i >> 1;
                        stb_key_q <= 1'b1;
                        bit_cnt_q <= BitW'(1);
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StKeyLoad;
                    end
                end
                StKeyLoad: begin
                    if (bit_cnt_q == BitW'(KeyBits)) begin
                        if (Warmup == 0) begin
                            tx_ready_q <= 1'b1;
                            state_q    <= StWaitTx;
                        end else begin
                            warm_cnt_q <= WarmW'(1);
                            state_q    <= StWarmup;
                        end
                    end else begin
                        key_q     <= key_sr_q[0];
                        key_sr_q  <= key_sr_q >> 1;
                        stb_key_q <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                    end
                end
                StWarmup: begin
                    if (warm_cnt_q == WarmW'(Warmup)) begin
                        tx_ready_q <= 1'b1;
                        state_q    <= StWaitTx;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + WarmW'(1);
                    end
                end
                StWaitTx: begin
                    if (tx_valid_i && tx_ready_q) begin
                        data_q     <= tx_data_i;
                        last_q     <= tx_last_i;
                        stb_data_q <= 1'b1;
                        state_q    <= StSend;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                StSend: begin
                    read_q  <= 1'b1;
                    state_q <= StReq;
                end
                StReq: begin
                    wait_cnt_q <= WaitW'(1);
                    state_q    <= StWaitRd;
                end
                StWaitRd: begin
                    // A strobe on the last permitted cycle is checked before the timeout.
                    if (stb_read_i) begin
                        rx_data_q  <= data_out_i;
                        rx_sign_q  <= sign_reg_i;
                        rx_valid_q <= 1'b1;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            tx_ready_q <= 1'b1;
                            state_q    <= StWaitTx;
                        end
                    end else if (wait_cnt_q >= WaitW'(Timeout)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WaitW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_sign_o  = rx_sign_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign key_o      = key_q;
    assign stb_key_o  = stb_key_q;
    assign data_o     = data_q;
    assign stb_data_o = stb_data_q;
    assign read_o     = read_q;

endmodule

// File: tb/tb_trv_host_driver.sv
// Directed bench for trv_host_driver: inline cycle checks for strobe timing plus a
// scoreboard that pairs each RX_VALID/DONE event with the response queued at stimulus time.
module tb_trv_host_driver;

    localparam int unsigned KeyBits = 80;
    localparam int unsigned Warmup  = 6;
    localparam int unsigned Timeout = 16;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               start_i;
    logic [KeyBits-1:0] key_in_i;
    logic [7:0]         tx_data_i;
    logic               tx_last_i;
    logic               tx_valid_i;
    logic               tx_ready_o;
    logic [7:0]         rx_data_o;
    logic [7:0]         rx_sign_o;
    logic               rx_valid_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic               key_o;
    logic               stb_key_o;
    logic [7:0]         data_o;
    logic               stb_data_o;
    logic               read_o;
    logic [7:0]         data_out_i;
    logic [7:0]         sign_reg_i;
    logic               stb_read_i;

    trv_host_driver #(
        .KeyBits(KeyBits),
        .Warmup (Warmup),
        .Timeout(Timeout)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .key_in_i  (key_in_i),
        .tx_data_i (tx_data_i),
        .tx_last_i (tx_last_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .rx_data_o (rx_data_o),
        .rx_sign_o (rx_sign_o),
        .rx_valid_o(rx_valid_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .key_o     (key_o),
        .stb_key_o (stb_key_o),
        .data_o    (data_o),
        .stb_data_o(stb_data_o),
        .read_o    (read_o),
        .data_out_i(data_out_i),
        .sign_reg_i(sign_reg_i),
        .stb_read_i(stb_read_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic [7:0] sign;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every RX_VALID or DONE must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rst_ni && (rx_valid_o || done_o)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: rx_valid=%0b done=%0b with empty scoreboard",
                         rx_valid_o, done_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_rx_valid", 32'(rx_valid_o), 32'(e.valid));
                check("sb_done", 32'(done_o), 32'(e.done));
                check("sb_err", 32'(err_o), 32'(e.err));
                if (e.valid) begin
                    check("sb_rx_data", 32'(rx_data_o), 32'(e.data));
                    check("sb_rx_sign", 32'(rx_sign_o), 32'(e.sign));
                end
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({tx_ready_o, rx_data_o, rx_sign_o, rx_valid_o, busy_o, done_o, err_o,
                    key_o, stb_key_o, data_o != 8'h00, stb_data_o, read_o});
    endfunction

    // Starts a session from IDLE and checks the key stream and warm-up gap.
    task automatic start_session(input logic [KeyBits-1:0] key, input bit stray);
        start_i  = 1'b1;
        key_in_i = key;
        @(negedge clk_i);
        start_i  = 1'b0;
        key_in_i = ~key;
        check("err_cleared", 32'(err_o), 32'd0);
        check("busy_on_start", 32'(busy_o), 32'd1);
        for (int k = 0; k < int'(KeyBits); k++) begin
            check("stb_key", 32'(stb_key_o), 32'd1);
            check("key_bit", 32'(key_o), 32'(key[k]));
            @(negedge clk_i);
        end
        for (int w = 0; w < int'(Warmup); w++) begin
            check("warmup_stb_key", 32'(stb_key_o), 32'd0);
            check("warmup_tx_ready", 32'(tx_ready_o), 32'd0);
            stb_read_i = stray && (w == 1);
            data_out_i = 8'hEE;
            @(negedge clk_i);
        end
        stb_read_i = 1'b0;
        check("tx_ready_after_warmup", 32'(tx_ready_o), 32'd1);
    endtask

    // delay = cycles from READ to STB_READ; 0 means the cipher never answers.
    task automatic send_byte(input logic [7:0] b, input bit last, input int delay,
                             input logic [7:0] dout, input logic [7:0] sign, input bit poke);
        int n = 0;
        int n_wait;
        exp_t e;
        while (!tx_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("tx_ready_wait", 32'(tx_ready_o), 32'd1);
        tx_valid_i = 1'b1;
        tx_data_i  = b;
        tx_last_i  = last;
        if (delay != 0) e = '{valid: 1'b1, data: dout, sign: sign, done: last, err: 1'b0};
        else            e = '{valid: 1'b0, data: 8'h00, sign: 8'h00, done: 1'b1, err: 1'b1};
        sb.push_back(e);
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        check("send_stb_data", 32'(stb_data_o), 32'd1);
        check("send_data", 32'(data_o), 32'(b));
        check("send_tx_ready", 32'(tx_ready_o), 32'd0);
        @(negedge clk_i);
        check("req_read", 32'(read_o), 32'd1);
        check("req_stb_data", 32'(stb_data_o), 32'd0);
        check("req_data_idle", 32'(data_o), 32'd0);
        n_wait = (delay == 0) ? int'(Timeout) + 1 : delay + 1;
        for (int i = 0; i < n_wait; i++) begin
            if (delay != 0 && i == delay) begin
                stb_read_i = 1'b1;
                data_out_i = dout;
                sign_reg_i = sign;
            end
            if (poke && i == 1) begin
                start_i  = 1'b1;
                key_in_i = '1;
            end
            @(negedge clk_i);
            stb_read_i = 1'b0;
            start_i    = 1'b0;
            data_out_i = 8'h00;
            sign_reg_i = 8'h00;
            if (i < n_wait - 1) begin
                check("wait_tx_ready", 32'(tx_ready_o), 32'd0);
                check("wait_done", 32'(done_o), 32'd0);
            end
        end
        check("end_done", 32'(done_o), 32'(last || delay == 0));
        check("end_busy", 32'(busy_o), 32'(!(last || delay == 0)));
        check("end_tx_ready", 32'(tx_ready_o), 32'(!last && delay != 0));
        check("end_err", 32'(err_o), 32'(delay == 0));
        check("end_stb_key", 32'(stb_key_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        key_in_i   = '0;
        tx_data_i  = 8'h00;
        tx_last_i  = 1'b0;
        tx_valid_i = 1'b0;
        data_out_i = 8'h00;
        sign_reg_i = 8'h00;
        stb_read_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", all_outs(), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Key stream, then one last byte answered four cycles after READ.
        start_session(80'h0123456789ABCDEF0011, 1'b0);
        send_byte(8'hA5, 1'b1, 4, 8'h3C, 8'h81, 1'b0);

        // Three bytes answered immediately.
        start_session(80'hFEDCBA9876543210A5C3, 1'b0);
        send_byte(8'h11, 1'b0, 1, 8'hEE, 8'h01, 1'b0);
        send_byte(8'h22, 1'b0, 1, 8'hDD, 8'h02, 1'b0);
        send_byte(8'h33, 1'b1, 1, 8'hCC, 8'h03, 1'b0);

        // Strobe on the final permitted cycle, then a real timeout.
        start_session(80'h00000000000000000001, 1'b0);
        send_byte(8'h5A, 1'b0, int'(Timeout), 8'h77, 8'h88, 1'b0);
        send_byte(8'h66, 1'b1, 0, 8'h00, 8'h00, 1'b0);
        @(negedge clk_i);
        check("err_sticky", 32'(err_o), 32'd1);
        check("idle_after_timeout", 32'(busy_o), 32'd0);
        start_session(80'h80000000000000000000, 1'b0);
        send_byte(8'h01, 1'b1, 2, 8'h10, 8'h20, 1'b0);

        // Reset while bit 40 of the key is on the wire.
        @(negedge clk_i);
        start_i  = 1'b1;
        key_in_i = 80'hAAAA5555AAAA5555AAAA;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 40; k++) @(negedge clk_i);
        check("bit40_stb_key", 32'(stb_key_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("midreset_outputs", all_outs(), 32'd0);
        @(negedge clk_i);
        check("midreset_idle", all_outs(), 32'd0);
        start_session(80'h13579BDF02468ACE1357, 1'b0);
        send_byte(8'hC7, 1'b1, 3, 8'h9E, 8'h42, 1'b0);

        // Stray STB_READ during warm-up and START during WAIT_RD are both ignored.
        start_session(80'h0F0F0F0F0F0F0F0F0F0F, 1'b1);
        send_byte(8'hB4, 1'b0, 3, 8'h4B, 8'hF0, 1'b1);
        send_byte(8'hD2, 1'b1, 2, 8'h2D, 8'h0F, 1'b0);
        repeat (5) @(negedge clk_i);
        check("idle_no_restart", 32'(busy_o), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
